// File: rtl/rx_command_sequencer_if.sv
// rtl/rx_command_sequencer_if.sv - byte handshake between UART receive wrapper and command sequencer
interface rx_command_sequencer_if;
  logic       DataAvailable;
  logic [7:0] CurrentData;
  logic       ClearData;

  modport master (output DataAvailable, output CurrentData, input ClearData);
  modport slave  (input DataAvailable, input CurrentData, output ClearData);
endinterface

// File: rtl/rx_command_sequencer.sv
// rtl/rx_command_sequencer.sv - receive packet parser driving config registers, arm and trigger
// Optional ACK/NAK transmit path is enabled by defining ACK_RESPONSE_EN.
module rx_command_sequencer #(
  parameter int         REG_COUNT      = 8,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] SOF_BYTE       = 8'hA5
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  rx_command_sequencer_if.slave  rx,
  input  logic                   AcqDone,
  output logic [8*REG_COUNT-1:0] RegFile,
  output logic                   RegWriteStrobe,
  output logic [3:0]             RegWriteAddr,
  output logic                   Arm,
  output logic                   SoftTrigger,
  output logic [7:0]             ErrorCount,
  output logic                   TxStart,
  output logic [7:0]             TxData,
  input  logic                   TxBusy
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_HI, GET_LO, COMMIT} state_t;

  state_t          state_q, state_d;
  logic [3:0]      addr_q, addr_d;
  logic [3:0]      hi_q, hi_d;
  logic [3:0]      lo_q, lo_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            clr_q, clr_dly_q;
  logic            strobe_q, trig_q, arm_q;
  logic [3:0]      waddr_q;
  logic [7:0]      err_cnt_q;
  logic [7:0]      regs_q [REG_COUNT];

  logic            sample, tmo_hit;
  logic [7:0]      b;
  logic            err_ev, ack_ev, arm_set, trig, wipe, commit;

  // ClearData cycle and the one after it are blind so a byte is never taken twice
  assign sample  = rx.DataAvailable && !clr_q && !clr_dly_q;
  assign b       = rx.CurrentData;
  assign tmo_hit = (state_q != IDLE) && (state_q != COMMIT) && !sample && (tmo_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    err_ev  = 1'b0;
    ack_ev  = 1'b0;
    arm_set = 1'b0;
    trig    = 1'b0;
    wipe    = 1'b0;
    commit  = 1'b0;
    if (tmo_hit) begin
      err_ev  = 1'b1;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (sample) begin
          if (b == SOF_BYTE) begin
            state_d = GET_ADDR;
          end else if (b == 8'hC1) begin
            arm_set = 1'b1;
            ack_ev  = 1'b1;
          end else if (b == 8'hC2) begin
            trig   = 1'b1;
            ack_ev = 1'b1;
          end else if (b == 8'hC3) begin
            wipe   = 1'b1;
            ack_ev = 1'b1;
          end else begin
            err_ev = 1'b1;
          end
        end
        GET_ADDR: if (sample) begin
          if (b[7:4] == 4'h4 && {1'b0, b[3:0]} < 5'(REG_COUNT)) begin
            addr_d  = b[3:0];
            state_d = GET_HI;
          end else if (b == SOF_BYTE) begin
            err_ev = 1'b1;
          end else begin
            err_ev  = 1'b1;
            state_d = IDLE;
          end
        end
        GET_HI, GET_LO: if (sample) begin
          if (b[7:4] == 4'h8) begin
            if (state_q == GET_HI) begin
              hi_d    = b[3:0];
              state_d = GET_LO;
            end else begin
              lo_d    = b[3:0];
              state_d = COMMIT;
            end
          end else begin
            err_ev  = 1'b1;
            state_d = (b == SOF_BYTE) ? GET_ADDR : IDLE;
          end
        end
        COMMIT: begin
          commit  = 1'b1;
          ack_ev  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    tmo_d = (sample || state_q == IDLE || tmo_hit) ? '0 : tmo_q + TW'(1);
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      tmo_q     <= '0;
      clr_q     <= 1'b0;
      clr_dly_q <= 1'b0;
      strobe_q  <= 1'b0;
      trig_q    <= 1'b0;
      arm_q     <= 1'b0;
      waddr_q   <= '0;
      err_cnt_q <= '0;
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      tmo_q     <= tmo_d;
      clr_q     <= sample;
      clr_dly_q <= clr_q;
      strobe_q  <= commit;
      trig_q    <= trig;
      if (commit) waddr_q <= addr_q;
      // a 0xC1 executing in the same cycle as AcqDone leaves the core armed
      if (arm_set)              arm_q <= 1'b1;
      else if (wipe || AcqDone) arm_q <= 1'b0;
      if (err_ev && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      for (int i = 0; i < REG_COUNT; i++) begin
        if (wipe)                             regs_q[i] <= '0;
        else if (commit && addr_q == 4'(i))   regs_q[i] <= {hi_q, lo_q};
      end
    end
  end

  for (genvar g = 0; g < REG_COUNT; g++) begin : g_regfile
    assign RegFile[8*g +: 8] = regs_q[g];
  end

  assign rx.ClearData    = clr_q;
  assign RegWriteStrobe  = strobe_q;
  assign RegWriteAddr    = waddr_q;
  assign Arm             = arm_q;
  assign SoftTrigger     = trig_q;
  assign ErrorCount      = err_cnt_q;

`ifdef ACK_RESPONSE_EN
  logic       pend_q;
  logic [7:0] pend_byte_q;
  logic       tx_start_q;
  logic [7:0] tx_data_q;

  // single pending slot; a fresh response replaces one the transmitter has not taken
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      pend_q      <= 1'b0;
      pend_byte_q <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      tx_start_q <= 1'b0;
      if (pend_q && !TxBusy) begin
        tx_start_q <= 1'b1;
        tx_data_q  <= pend_byte_q;
        pend_q     <= 1'b0;
      end
      if (ack_ev) begin
        pend_q      <= 1'b1;
        pend_byte_q <= 8'h06;
      end else if (err_ev) begin
        pend_q      <= 1'b1;
        pend_byte_q <= 8'h15;
      end
    end
  end

  assign TxStart = tx_start_q;
  assign TxData  = tx_data_q;
`else
  logic unused_ok;
  assign unused_ok = ^{TxBusy, ack_ev};
  assign TxStart   = 1'b0;
  assign TxData    = 8'h00;
`endif

endmodule

// File: tb/tb_rx_command_sequencer.sv
// tb/tb_rx_command_sequencer.sv - directed vector bench for rx_command_sequencer
module tb_rx_command_sequencer;

  localparam int RC = 8;

  logic          Clock = 1'b0;
  logic          Reset_n = 1'b0;
  logic          AcqDone = 1'b0;
  logic          TxBusy = 1'b0;
  logic [8*RC-1:0] RegFile;
  logic          RegWriteStrobe;
  logic [3:0]    RegWriteAddr;
  logic          Arm;
  logic          SoftTrigger;
  logic [7:0]    ErrorCount;
  logic          TxStart;
  logic [7:0]    TxData;

  rx_command_sequencer_if rxi ();

  rx_command_sequencer #(.REG_COUNT(RC), .TIMEOUT_CYCLES(50), .SOF_BYTE(8'hA5)) dut (
    .Clock          (Clock),
    .Reset_n        (Reset_n),
    .rx             (rxi),
    .AcqDone        (AcqDone),
    .RegFile        (RegFile),
    .RegWriteStrobe (RegWriteStrobe),
    .RegWriteAddr   (RegWriteAddr),
    .Arm            (Arm),
    .SoftTrigger    (SoftTrigger),
    .ErrorCount     (ErrorCount),
    .TxStart        (TxStart),
    .TxData         (TxData),
    .TxBusy         (TxBusy)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_err    = 0;
  int bytes_sent = 0;
  int clr_cnt = 0, clr_viol = 0;
  int strb_cnt = 0, strb_viol = 0;
  int trig_cnt = 0, trig_viol = 0;
  int tx_cnt = 0;
  logic clr_prev = 1'b0, strb_prev = 1'b0, trig_prev = 1'b0;

  always @(negedge Clock) begin
    if (rxi.ClearData) clr_cnt++;
    if (rxi.ClearData && clr_prev) clr_viol++;
    if (RegWriteStrobe) strb_cnt++;
    if (RegWriteStrobe && strb_prev) strb_viol++;
    if (SoftTrigger) trig_cnt++;
    if (SoftTrigger && trig_prev) trig_viol++;
    if (TxStart) tx_cnt++;
    clr_prev  = rxi.ClearData;
    strb_prev = RegWriteStrobe;
    trig_prev = SoftTrigger;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic send(input logic [7:0] v);
    int n;
    @(negedge Clock);
    rxi.DataAvailable = 1'b1;
    rxi.CurrentData   = v;
    n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (!rxi.ClearData && n < 20);
    if (!rxi.ClearData) begin
      n_checks++;
      n_err++;
      $display("FAIL clear_wait: got no ClearData for byte 0x%0h within 20 cycles", v);
    end
    rxi.DataAvailable = 1'b0;
    bytes_sent++;
    idle(3);
  endtask

  typedef struct {
    logic [7:0] data;
    int         exp_err;
    logic       exp_arm;
    int         idx;
    logic [7:0] exp_val;
    int         exp_strb;
    int         exp_trig;
    logic [3:0] exp_waddr;
  } vec_t;

  vec_t vecs [29];

  initial begin
    int strb_base;
    rxi.DataAvailable = 1'b0;
    rxi.CurrentData   = 8'h00;

    vecs[0]  = '{8'hA5, 0, 1'b0, 3, 8'h00, 0, 0, 4'd0};
    vecs[1]  = '{8'h43, 0, 1'b0, 3, 8'h00, 0, 0, 4'd0};
    vecs[2]  = '{8'h8B, 0, 1'b0, 3, 8'h00, 0, 0, 4'd0};
    vecs[3]  = '{8'h8C, 0, 1'b0, 3, 8'hBC, 1, 0, 4'd3};
    vecs[4]  = '{8'hC1, 0, 1'b1, 3, 8'hBC, 1, 0, 4'd3};
    vecs[5]  = '{8'hC2, 0, 1'b1, 3, 8'hBC, 1, 1, 4'd3};
    vecs[6]  = '{8'hA5, 0, 1'b1, 3, 8'hBC, 1, 1, 4'd3};
    vecs[7]  = '{8'h49, 1, 1'b1, 3, 8'hBC, 1, 1, 4'd3};
    vecs[8]  = '{8'h37, 2, 1'b1, 3, 8'hBC, 1, 1, 4'd3};
    vecs[9]  = '{8'hC3, 2, 1'b0, 3, 8'h00, 1, 1, 4'd3};
    vecs[10] = '{8'hA5, 2, 1'b0, 0, 8'h00, 1, 1, 4'd3};
    vecs[11] = '{8'h40, 2, 1'b0, 0, 8'h00, 1, 1, 4'd3};
    vecs[12] = '{8'h81, 2, 1'b0, 0, 8'h00, 1, 1, 4'd3};
    vecs[13] = '{8'h82, 2, 1'b0, 0, 8'h12, 2, 1, 4'd0};
    vecs[14] = '{8'hA5, 2, 1'b0, 0, 8'h12, 2, 1, 4'd0};
    vecs[15] = '{8'h40, 2, 1'b0, 0, 8'h12, 2, 1, 4'd0};
    vecs[16] = '{8'h80, 2, 1'b0, 0, 8'h12, 2, 1, 4'd0};
    vecs[17] = '{8'h80, 2, 1'b0, 0, 8'h00, 3, 1, 4'd0};
    vecs[18] = '{8'hFF, 3, 1'b0, 0, 8'h00, 3, 1, 4'd0};
    vecs[19] = '{8'hC4, 4, 1'b0, 0, 8'h00, 3, 1, 4'd0};
    vecs[20] = '{8'hA5, 4, 1'b0, 2, 8'h00, 3, 1, 4'd0};
    vecs[21] = '{8'hA5, 5, 1'b0, 2, 8'h00, 3, 1, 4'd0};
    vecs[22] = '{8'h42, 5, 1'b0, 2, 8'h00, 3, 1, 4'd0};
    vecs[23] = '{8'h8A, 5, 1'b0, 2, 8'h00, 3, 1, 4'd0};
    vecs[24] = '{8'hA5, 6, 1'b0, 2, 8'h00, 3, 1, 4'd0};
    vecs[25] = '{8'h42, 6, 1'b0, 2, 8'h00, 3, 1, 4'd0};
    vecs[26] = '{8'h83, 6, 1'b0, 2, 8'h00, 3, 1, 4'd0};
    vecs[27] = '{8'h84, 6, 1'b0, 2, 8'h34, 4, 1, 4'd2};
    vecs[28] = '{8'hC3, 6, 1'b0, 2, 8'h00, 4, 1, 4'd2};

    repeat (3) @(negedge Clock);
    chk("rst_regfile", 64'(RegFile), 64'd0);
    chk("rst_arm",     64'(Arm), 64'd0);
    chk("rst_errcnt",  64'(ErrorCount), 64'd0);
    chk("rst_clear",   64'(rxi.ClearData), 64'd0);
    chk("rst_strobe",  64'(RegWriteStrobe), 64'd0);
    Reset_n = 1'b1;
    idle(2);

    for (int i = 0; i < 29; i++) begin
      send(vecs[i].data);
      chk($sformatf("v%0d_errcnt", i), 64'(ErrorCount), 64'(vecs[i].exp_err));
      chk($sformatf("v%0d_arm", i),    64'(Arm), 64'(vecs[i].exp_arm));
      chk($sformatf("v%0d_reg%0d", i, vecs[i].idx), 64'(RegFile[vecs[i].idx*8 +: 8]), 64'(vecs[i].exp_val));
      chk($sformatf("v%0d_strobes", i), 64'(strb_cnt), 64'(vecs[i].exp_strb));
      chk($sformatf("v%0d_trigs", i),   64'(trig_cnt), 64'(vecs[i].exp_trig));
      chk($sformatf("v%0d_waddr", i),   64'(RegWriteAddr), 64'(vecs[i].exp_waddr));
      chk($sformatf("v%0d_clears", i),  64'(clr_cnt), 64'(i + 1));
    end

    // arm set, cleared by AcqDone, then set wins over a coincident AcqDone
    send(8'hC1);
    chk("arm_set", 64'(Arm), 64'd1);
    @(negedge Clock) AcqDone = 1'b1;
    @(negedge Clock) AcqDone = 1'b0;
    chk("arm_acqdone_clr", 64'(Arm), 64'd0);
    @(negedge Clock);
    rxi.DataAvailable = 1'b1;
    rxi.CurrentData   = 8'hC1;
    AcqDone           = 1'b1;
    @(negedge Clock);
    AcqDone = 1'b0;
    chk("coinc_sampled", 64'(rxi.ClearData), 64'd1);
    rxi.DataAvailable = 1'b0;
    bytes_sent++;
    idle(3);
    chk("arm_set_wins", 64'(Arm), 64'd1);

    // partial packet abandoned by timeout
    send(8'hA5); send(8'h41); send(8'h85);
    idle(60);
    chk("tmo_errcnt",  64'(ErrorCount), 64'd7);
    chk("tmo_nowrite", 64'(strb_cnt), 64'd4);
    chk("tmo_reg1",    64'(RegFile[15:8]), 64'h00);

    // recovery write with exact commit latency
    send(8'hA5); send(8'h41); send(8'h85);
    @(negedge Clock);
    rxi.DataAvailable = 1'b1;
    rxi.CurrentData   = 8'h86;
    @(negedge Clock);
    chk("lat_sampled", 64'(rxi.ClearData), 64'd1);
    chk("lat_reg1_before", 64'(RegFile[15:8]), 64'h00);
    rxi.DataAvailable = 1'b0;
    bytes_sent++;
    @(negedge Clock);
    chk("lat_reg1_after", 64'(RegFile[15:8]), 64'h56);
    chk("lat_strobe",     64'(RegWriteStrobe), 64'd1);
    chk("lat_waddr",      64'(RegWriteAddr), 64'd1);
    @(negedge Clock);
    chk("lat_strobe_end", 64'(RegWriteStrobe), 64'd0);
    idle(2);

    // reset mid-packet
    send(8'hC1);
    send(8'hA5); send(8'h42);
    strb_base = strb_cnt;
    @(negedge Clock);
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_regfile", 64'(RegFile), 64'd0);
    chk("mid_rst_arm",     64'(Arm), 64'd0);
    chk("mid_rst_errcnt",  64'(ErrorCount), 64'd0);
    chk("mid_rst_waddr",   64'(RegWriteAddr), 64'd0);
    chk("mid_rst_outs",    64'({rxi.ClearData, RegWriteStrobe, SoftTrigger, TxStart, TxData}), 64'd0);
    idle(2);
    Reset_n = 1'b1;
    idle(2);
    send(8'h8F); send(8'h8F);
    chk("post_rst_errcnt",  64'(ErrorCount), 64'd2);
    chk("post_rst_nowrite", 64'(strb_cnt), 64'(strb_base));
    chk("post_rst_regfile", 64'(RegFile), 64'd0);

`ifdef ACK_RESPONSE_EN
    begin
      int tx_base;
      idle(4);
      tx_base = tx_cnt;
      TxBusy  = 1'b1;
      send(8'hA5); send(8'h40); send(8'h81); send(8'h82);
      idle(4);
      chk("ack_held_busy", 64'(tx_cnt), 64'(tx_base));
      TxBusy = 1'b0;
      idle(4);
      chk("ack_sent_cnt", 64'(tx_cnt), 64'(tx_base + 1));
      chk("ack_byte",     64'(TxData), 64'h06);
      send(8'h7E);
      idle(2);
      chk("nak_sent_cnt", 64'(tx_cnt), 64'(tx_base + 2));
      chk("nak_byte",     64'(TxData), 64'h15);
    end
`else
    chk("no_txstart", 64'(tx_cnt), 64'd0);
    chk("no_txdata",  64'(TxData), 64'd0);
`endif

    chk("clear_total",  64'(clr_cnt), 64'(bytes_sent));
    chk("clear_width",  64'(clr_viol), 64'd0);
    chk("strobe_width", 64'(strb_viol), 64'd0);
    chk("trig_width",   64'(trig_viol), 64'd0);
    chk("trig_total",   64'(trig_cnt), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/rx_command_sequencer.md
Name: rx_command_sequencer

Overview:
Command-layer controller for the serial receive path. Drains bytes from the UART receive wrapper via its DataAvailable/ClearData handshake and parses a fixed packet protocol. Executes register writes into a local configuration register file and issues arm and trigger controls to the acquisition core. All protocol bytes are nonzero, because the receive wrapper cannot signal a 0x00 byte.

Parameters:
REG_COUNT, 8, number of 8-bit config registers; legal 1..16
TIMEOUT_CYCLES, 1000000, max Clock cycles between bytes of one packet before abort
SOF_BYTE, 8'hA5, start-of-frame byte for register-write packets

Ports:
Clock  in  1  system clock, all logic on posedge
Reset_n  in  1  asynchronous active-low reset
DataAvailable  in  1  receive wrapper holds an unconsumed byte
CurrentData  in  8  byte held by receive wrapper
ClearData  out  1  one-cycle consume pulse to receive wrapper
AcqDone  in  1  acquisition core finished; clears Arm
RegFile  out  8*REG_COUNT  flattened config registers, reg i at [8i+7:8i]
RegWriteStrobe  out  1  one-cycle pulse when a register is written
RegWriteAddr  out  4  address of last write
Arm  out  1  acquisition armed, level
SoftTrigger  out  1  one-cycle software trigger pulse
ErrorCount  out  8  saturating count of protocol errors
TxStart  out  1  ack transmit request (optional feature)
TxData  out  8  ack byte (optional feature)
TxBusy  in  1  transmitter busy (optional feature)

Behaviour:
- Reset (async, Reset_n low): all outputs 0, RegFile all 0, FSM IDLE, timeout counter 0.
- Consume handshake: when DataAvailable=1 and sampling is not inhibited, byte latched that cycle; ClearData registered high exactly the next cycle. Sampling is inhibited during the ClearData cycle and the cycle after it, so each byte is consumed exactly once.
- Parse FSM: IDLE, GET_ADDR, GET_HI, GET_LO, COMMIT. Transitions are evaluated on each consumed byte.
- IDLE:
  - SOF_BYTE -> GET_ADDR.
  - 0xC1 -> Arm=1.
  - 0xC2 -> SoftTrigger pulse.
  - 0xC3 -> RegFile cleared to 0 and Arm=0.
  - Any other byte -> error; stay IDLE.
- GET_ADDR:
  - 0x40|a with a<REG_COUNT -> latch a, go to GET_HI.
  - SOF_BYTE -> error; stay GET_ADDR (resync).
  - Any other byte -> error; go to IDLE.
- GET_HI: 0x80|n -> latch hi nibble n, go to GET_LO. Else: error; IDLE (SOF_BYTE goes to GET_ADDR instead).
- GET_LO: 0x80|n -> COMMIT. Else: as for GET_HI.
- COMMIT, one cycle:
  - RegFile[a] <= {hi,lo}.
  - RegWriteAddr <= a.
  - RegWriteStrobe pulses.
  - Next state IDLE.
  - Latency: write visible 2 cycles after the cycle the last byte is sampled.
- Timeout: counter cleared on each consumed byte and in IDLE, otherwise increments. At TIMEOUT_CYCLES-1: error, go to IDLE, partial packet discarded with no register change.
- Arm: set by 0xC1, cleared by AcqDone=1 or 0xC3. If 0xC1 execution and AcqDone coincide, set wins.
- ErrorCount: +1 per error event, saturates at 255, cleared only by reset.
- Data register value 0x00 is writable (nibble encoding); command bytes 0xC4..0xFF are errors.

Optional Feature:
ACK_RESPONSE_EN
- Defined:
  - After each COMMIT or executed 0xC1..0xC3, the block queues ACK byte 0x06.
  - After each error, it queues NAK byte 0x15.
  - Single-entry pending slot; a newer response overwrites an unsent one.
  - When the slot is full and TxBusy=0: TxData driven with the byte, TxStart pulses one cycle, slot empties.
- Undefined: TxStart=0 and TxData=0 constantly; TxBusy ignored.

Test Plan:
- Bytes A5,43,8B,8C with REG_COUNT=8 -> RegFile[3]=0xBC, RegWriteStrobe one pulse, RegWriteAddr=3, ClearData exactly 4 single-cycle pulses, ErrorCount=0.
- Byte C1, then AcqDone pulse; then C1 and AcqDone in the same execute cycle -> Arm=1, then 0, then 1; byte C2 -> SoftTrigger single pulse.
- Bytes A5,49 with REG_COUNT=8 -> ErrorCount=1, FSM IDLE, RegFile unchanged; follow with 37 -> ErrorCount=2.
- Bytes A5,41,85, then idle TIMEOUT_CYCLES (set 50) -> ErrorCount+1, no write; then A5,41,85,86 -> RegFile[1]=0x56.
- Reset_n asserted low mid-packet after A5,42 -> all outputs 0 immediately; after release, bytes 8F,8F -> 2 errors, no write.
- With ACK_RESPONSE_EN and TxBusy held 1 then released: A5,40,81,82 -> no TxStart while busy; after release, one TxStart with TxData=0x06; byte 00-free junk 7E -> TxData=0x15.
